// File: rtl/mux41_pkg.sv
// Shared types and helpers for the mux41 round-robin arbiter slice.
package mux41_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   // Index of the set bit in a one-hot vector; 0 when no bit is set.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux41.sv
// 4:1 single-bit multiplexer (existing datapath block).
module mux41
   import mux41_pkg::*;
(
   input  logic             i0,
   input  logic             i1,
   input  logic             i2,
   input  logic             i3,
   input  logic [SEL_W-1:0] sel,
   output logic             out
);

   // Pure combinational select.
   always_comb begin
      out = i0;
      case (sel)
         2'd0: out = i0;
         2'd1: out = i1;
         2'd2: out = i2;
         2'd3: out = i3;
         default: out = i0;
      endcase
   end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one mux41 among four requesters.
// The owner keeps the mux for up to MAX_BURST accepted beats, then ownership
// rotates; a release re-arbitrates in the same cycle, so there is no idle bubble.
module mux41_rr_arbiter
   import mux41_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] d,
   input  logic             out_ready,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] sel,
   output logic             out_valid,
   output logic             out_data
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] owner;
   logic [SEL_W-1:0] base;
   logic [SEL_W-1:0] win;
   logic             win_any;
   logic             beat;
   logic             at_limit;
   logic             rel;

   assign owner    = onehot_to_idx(grant);
   assign beat     = out_valid & out_ready;
   assign at_limit = (cnt == CNT_W'(MAX_BURST - 1));
   assign rel      = ~req[owner] | (beat & at_limit);

   // Scan starts after the last owner when idle, after the current owner when granted.
   assign base = (state == GRANT) ? owner : ptr;

   // Round-robin pick: first requester at base+1, base+2, ... wrapping mod 4.
   always_comb begin
      logic [SEL_W-1:0] cand;
      win     = '0;
      win_any = 1'b0;
      cand    = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = base + SEL_W'(k);
         if (!win_any && req[cand]) begin
            win_any = 1'b1;
            win     = cand;
         end
      end
   end

   // Arbiter FSM with registered grant/sel/out_valid, burst counter and last-owner pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         sel       <= '0;
         out_valid <= 1'b0;
         cnt       <= '0;
         ptr       <= '1;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state     <= GRANT;
                  grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                  sel       <= win;
                  out_valid <= 1'b1;
                  cnt       <= '0;
               end
            end
            GRANT: begin
               if (rel) begin
                  ptr <= owner;
                  cnt <= '0;
                  if (win_any) begin
                     grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                     sel       <= win;
                     out_valid <= 1'b1;
                  end else begin
                     state     <= IDLE;
                     grant     <= '0;
                     out_valid <= 1'b0;
                  end
               end else if (beat) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state     <= IDLE;
               grant     <= '0;
               out_valid <= 1'b0;
               cnt       <= '0;
            end
         endcase
      end
   end

   // Datapath: selected bit straight from the registered select.
   mux41 u_mux41 (
      .i0  (d[0]),
      .i1  (d[1]),
      .i2  (d[2]),
      .i3  (d[3]),
      .sel (sel),
      .out (out_data)
   );

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Bench for mux41_rr_arbiter: two instances (MAX_BURST 8 and 2) share stimulus
// and are compared against an integer-level round-robin ownership model.
module tb_mux41_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] d;
   logic       out_ready;

   logic [3:0] grant8, grant2;
   logic [1:0] sel8, sel2;
   logic       ov8, ov2, od8, od2;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: owner (-1 = idle), beats taken, last owner, held select.
   int m_max   [2] = '{8, 2};
   int m_owner [2];
   int m_beats [2];
   int m_last  [2];
   int m_sel   [2];

   always #5 clk = ~clk;

   mux41_rr_arbiter #(.MAX_BURST(8), .CNT_W(4)) u_b8 (
      .clk(clk), .rst_n(rst_n), .req(req), .d(d), .out_ready(out_ready),
      .grant(grant8), .sel(sel8), .out_valid(ov8), .out_data(od8)
   );

   mux41_rr_arbiter #(.MAX_BURST(2), .CNT_W(4)) u_b2 (
      .clk(clk), .rst_n(rst_n), .req(req), .d(d), .out_ready(out_ready),
      .grant(grant2), .sel(sel2), .out_valid(ov2), .out_data(od2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input int from, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1;
         m_beats[i] = 0;
         m_last[i]  = 3;
         m_sel[i]   = 0;
      end
   endtask

   task automatic model_step();
      int  w;
      bit  bt, rl;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         if (m_owner[i] < 0) begin
            w = pick(m_last[i], req);
            if (w >= 0) begin
               m_owner[i] = w;
               m_beats[i] = 0;
               m_sel[i]   = w;
            end
         end else begin
            bt = out_ready;
            if (bt) m_beats[i]++;
            rl = !req[m_owner[i]] || (bt && m_beats[i] == m_max[i]);
            if (rl) begin
               m_last[i]  = m_owner[i];
               w          = pick(m_owner[i], req);
               m_owner[i] = w;
               m_beats[i] = 0;
               if (w >= 0) m_sel[i] = w;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] g;
      logic [1:0] s;
      logic       v, o;
      for (int i = 0; i < 2; i++) begin
         g = (i == 0) ? grant8 : grant2;
         s = (i == 0) ? sel8   : sel2;
         v = (i == 0) ? ov8    : ov2;
         o = (i == 0) ? od8    : od2;
         check($sformatf("%s/b%0d/grant", tag, m_max[i]), g,
               (m_owner[i] < 0) ? 32'h0 : (32'h1 << m_owner[i]));
         check($sformatf("%s/b%0d/sel", tag, m_max[i]), s, m_sel[i]);
         check($sformatf("%s/b%0d/valid", tag, m_max[i]), v, (m_owner[i] >= 0) ? 1 : 0);
         if (m_owner[i] >= 0)
            check($sformatf("%s/b%0d/data", tag, m_max[i]), o, d[m_sel[i]]);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
   endtask

   // Async reset applied between edges: outputs must clear without waiting for a clock.
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "/grant0"}, grant8 | grant2, 0);
      check({tag, "/valid0"}, {ov8, ov2}, 0);
      check({tag, "/sel0"}, {sel8, sel2}, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 4'b1111;
      d         = 4'b0000;
      out_ready = 1'b1;
      model_reset();

      // Reset held with all requesting: nothing granted.
      for (int i = 0; i < 4; i++) begin
         tick("t1");
         check("t1_grant", {grant8, grant2}, 0);
      end

      // Single requester, burst of 8 then seamless re-grant.
      req = 4'b0000;
      rst_n = 1'b1;
      tick("t2_idle");
      req = 4'b0001;
      tick("t2_first");
      check("t2_grant", grant8, 4'b0001);
      for (int i = 0; i < 10; i++) begin
         tick("t2_burst");
         check("t2_nogap", ov8, 1'b1);
      end

      // All requesting, burst of 2 rotation on the short instance.
      async_reset("t3_rst");
      rst_n = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 9; k++) begin
         tick("t3");
         check("t3_sel_seq", sel2, (k / 2) % 4);
      end

      // Owner 2 stalled, then drops with 1001 pending: 3 wins over 0.
      async_reset("t4_rst");
      rst_n = 1'b1;
      req = 4'b0100;
      tick("t4_grant");
      check("t4_owner2", grant8, 4'b0100);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick("t4_stall");
         check("t4_hold", grant8, 4'b0100);
      end
      req = 4'b1001;
      tick("t4_rel");
      check("t4_next", sel8, 2'd3);
      out_ready = 1'b1;

      // Data path for d=1010 across owners 1..3.
      async_reset("t5_rst");
      rst_n = 1'b1;
      d = 4'b1010;
      for (int o = 1; o < 4; o++) begin
         req = 4'b0001 << o;
         tick("t5");
         if (sel8 == o[1:0])
            check($sformatf("t5_data%0d", o), od8, (o == 2) ? 0 : 1);
         else
            check($sformatf("t5_sel%0d", o), sel8, o);
      end

      // Reset mid-burst of owner 3, then requester 0 is first after release.
      req = 4'b1000;
      tick("t6_a");
      tick("t6_b");
      async_reset("t6_rst");
      tick("t6_held");
      rst_n = 1'b1;
      req = 4'b1001;
      tick("t6_after");
      check("t6_first0", grant8, 4'b0001);

      // Randomized traffic with occasional async reset pulses.
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(7, 0) == 0) req = 4'($urandom);
         d = 4'($urandom);
         out_ready = ($urandom_range(3, 0) != 0);
         if ($urandom_range(299, 0) == 0) begin
            async_reset("rnd_rst");
            rst_n = 1'b1;
         end
         tick("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
